// File: rtl/gamepad_responder.sv
// NES-style controller emulator: answers the reader's latch/pulse protocol on GamePadData.
// Optional per-button debounce filter is enabled by defining GP_DEBOUNCE_EN.
module gamepad_responder #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  Buttons,
    input  logic        GLatch,
    input  logic        GPulse,
    output logic        GamePadData,
    output logic        ReadDone,
    output logic [15:0] Polls
);

    // [0],[1] form the synchronizer; [2] holds the previous level for edge detection.
    logic [2:0] latch_sync;
    logic [2:0] pulse_sync;
    logic [7:0] btn_s1;
    logic [7:0] btn_s2;
    logic [7:0] btn;
    logic [7:0] shreg;
    logic [3:0] idx;

    logic latch_lvl;
    logic latch_rise;
    logic pulse_rise;

    assign latch_lvl   = latch_sync[1];
    assign latch_rise  = latch_sync[1] & ~latch_sync[2];
    assign pulse_rise  = pulse_sync[1] & ~pulse_sync[2];
    assign GamePadData = shreg[0];

`ifdef GP_DEBOUNCE_EN
    logic [15:0] db_cnt [8];
    logic [7:0]  btn_filt;

    // A filtered bit flips only after the raw bit disagrees for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            btn_filt <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                db_cnt[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (btn_s2[i] != btn_filt[i]) begin
                    if (db_cnt[i] >= DEBOUNCE_CYCLES - 16'd1) begin
                        btn_filt[i] <= btn_s2[i];
                        db_cnt[i]   <= 16'h0000;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 16'd1;
                    end
                end else begin
                    db_cnt[i] <= 16'h0000;
                end
            end
        end
    end

    assign btn = btn_filt;
`else
    logic unused_debounce_cycles;
    assign unused_debounce_cycles = ^DEBOUNCE_CYCLES;
    assign btn = btn_s2;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            latch_sync <= 3'b000;
            pulse_sync <= 3'b000;
            btn_s1     <= 8'h00;
            btn_s2     <= 8'h00;
            shreg      <= 8'hFF;
            idx        <= 4'd0;
            ReadDone   <= 1'b0;
            Polls      <= 16'h0000;
        end else begin
            latch_sync <= {latch_sync[1:0], GLatch};
            pulse_sync <= {pulse_sync[1:0], GPulse};
            btn_s1     <= Buttons;
            btn_s2     <= btn_s1;
            ReadDone   <= 1'b0;

            if (latch_rise) begin
                Polls <= Polls + 16'd1;
            end

            // Latch has priority: a pulse edge seen while latched is dropped.
            if (latch_lvl) begin
                shreg <= ~btn;
                idx   <= 4'd0;
            end else if (pulse_rise) begin
                shreg <= {1'b1, shreg[7:1]};
                if (idx != 4'd8) begin
                    idx <= idx + 4'd1;
                end
                if (idx == 4'd7) begin
                    ReadDone <= 1'b1;
                end
            end
        end
    end

endmodule
